// File: rtl/sb_defs_pkg.sv
// Shared register-write scoreboard definitions: register count, return-address
// register, destination-select encodings and counter limits.
package sb_defs_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    localparam logic [2:0] RA_REG = 3'd7;

    // Destination field select, shared with the control decoder and RAW check.
    typedef enum logic [1:0] {
        WSEL_HI  = 2'b00,  // instr[7:5]
        WSEL_LO  = 2'b01,  // instr[4:2]
        WSEL_MID = 2'b10,  // instr[10:8]
        WSEL_RA  = 2'b11   // R7 (JAL/JALR link)
    } wsel_e;

endpackage

// File: rtl/reg_write_scoreboard_dest_reg_decode.sv
// Destination register decode: picks the written register from the instruction
// word according to the write-select code. Purely combinational.
module dest_reg_decode
    import sb_defs_pkg::*;
(
    input  logic [15:0] i_instr,
    input  logic [1:0]  i_wr_sel,
    output logic [2:0]  o_wr_reg
);

    logic [2:0] w_wr_reg;

    always_comb begin
        w_wr_reg = RA_REG;
        case (wsel_e'(i_wr_sel))
            WSEL_HI:  w_wr_reg = i_instr[7:5];
            WSEL_LO:  w_wr_reg = i_instr[4:2];
            WSEL_MID: w_wr_reg = i_instr[10:8];
            WSEL_RA:  w_wr_reg = RA_REG;
            default:  w_wr_reg = RA_REG;
        endcase
    end

    assign o_wr_reg = w_wr_reg;

endmodule

// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: per-register pending-write counters, decode stall,
// busy vector and sticky retire-underflow error. Option macro: SB_WB_BYPASS_EN.
module reg_write_scoreboard
    import sb_defs_pkg::*;
#(
    parameter int unsigned NUM_REGS = sb_defs_pkg::NUM_REGS,
    parameter int unsigned CNT_W    = sb_defs_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid,
    input  logic [15:0]         iss_instr,
    input  logic                iss_wr_en,
    input  logic [1:0]          iss_wr_sel,
    input  logic                rd1_en,
    input  logic                rd2_en,
    input  logic [2:0]          rd1,
    input  logic [2:0]          rd2,
    input  logic                wb_valid,
    input  logic [2:0]          wb_reg,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic                r_err;

    logic [2:0]          w_wr_reg;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_rd_busy;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_stall;
    logic                w_accept;

    dest_reg_decode u_dest (
        .i_instr  (iss_instr),
        .i_wr_sel (iss_wr_sel),
        .o_wr_reg (w_wr_reg)
    );

    always_comb begin
        w_busy    = '0;
        w_rd_busy = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_busy[r]    = (r_cnt[r] != '0);
            w_rd_busy[r] = w_busy[r];
`ifdef SB_WB_BYPASS_EN
            // Last pending write retiring now is forwarded by the register file.
            if (wb_valid && (wb_reg == 3'(r)) && (r_cnt[r] == CNT_ONE))
                w_rd_busy[r] = 1'b0;
`endif
        end
    end

    always_comb begin
        w_stall  = (rd1_en & w_rd_busy[rd1])
                 | (rd2_en & w_rd_busy[rd2])
                 | (iss_valid & iss_wr_en & (r_cnt[w_wr_reg] == CNT_FULL));
        w_accept = iss_valid & iss_wr_en & ~w_stall & ~flush;
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = w_accept & (w_wr_reg == 3'(r));
            w_dec[r] = wb_valid & (wb_reg == 3'(r)) & w_busy[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
        end else if (flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (w_inc[r] && !w_dec[r])
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                else if (w_dec[r] && !w_inc[r])
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
            end
        end
    end

    // Retire with nothing pending is a pipeline bug; flush cycles are exempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (wb_valid && !flush && !w_busy[wb_reg])
            r_err <= 1'b1;
    end

    assign stall  = w_stall;
    assign busy   = w_busy;
    assign sb_err = r_err;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench for reg_write_scoreboard: directed scenarios followed by
// random traffic, all checked against a counter-array reference model.
module tb_reg_write_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid = 1'b0;
    logic [15:0] iss_instr = '0;
    logic        iss_wr_en = 1'b0;
    logic [1:0]  iss_wr_sel = '0;
    logic        rd1_en = 1'b0, rd2_en = 1'b0;
    logic [2:0]  rd1 = '0, rd2 = '0;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_reg = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [7:0]  busy;
    logic        sb_err;

    int total = 0;
    int bad   = 0;
    int cnt_m [8];
    bit err_m;

    reg_write_scoreboard #(.NUM_REGS(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_instr(iss_instr), .iss_wr_en(iss_wr_en),
        .iss_wr_sel(iss_wr_sel), .rd1_en(rd1_en), .rd2_en(rd2_en),
        .rd1(rd1), .rd2(rd2), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .flush(flush), .stall(stall), .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_dest();
        case (iss_wr_sel)
            2'd0:    return int'(iss_instr[7:5]);
            2'd1:    return int'(iss_instr[4:2]);
            2'd2:    return int'(iss_instr[10:8]);
            default: return 7;
        endcase
    endfunction

    function automatic bit m_rd_busy(input int r);
        if (cnt_m[r] == 0) return 1'b0;
        if (BYP && wb_valid && int'(wb_reg) == r && cnt_m[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = (rd1_en && m_rd_busy(int'(rd1))) || (rd2_en && m_rd_busy(int'(rd2)));
        s = s || (iss_valid && iss_wr_en && cnt_m[m_dest()] == MAXC);
        return s;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = (cnt_m[r] > 0);
        return b;
    endfunction

    task automatic idle();
        iss_valid = 1'b0; iss_wr_en = 1'b0; iss_wr_sel = '0; iss_instr = '0;
        rd1_en = 1'b0; rd2_en = 1'b0; rd1 = '0; rd2 = '0;
        wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [15:0] instr);
        iss_valid = 1'b1; iss_wr_en = 1'b1; iss_wr_sel = sel; iss_instr = instr;
    endtask

    // One clock: stall checked before the edge, model advanced, state checked after.
    task automatic cycle(input string tag);
        bit acc;
        int old [8];
        int d;
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, m_stall()});
        acc = iss_valid && iss_wr_en && !m_stall() && !flush;
        d   = m_dest();
        @(posedge clk);
        if (flush) begin
            for (int r = 0; r < 8; r++) cnt_m[r] = 0;
        end else begin
            old = cnt_m;
            if (acc) cnt_m[d]++;
            if (wb_valid) begin
                if (old[wb_reg] != 0) cnt_m[wb_reg]--;
                else err_m = 1'b1;
            end
        end
        #1;
        chk({tag, ".busy"}, {24'd0, busy}, {24'd0, m_busy()});
        chk({tag, ".sb_err"}, {31'd0, sb_err}, {31'd0, err_m});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int r = 0; r < 8; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        #2;
        chk("rst.busy", {24'd0, busy}, 32'd0);
        chk("rst.sb_err", {31'd0, sb_err}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cands[$];
        idle();
        for (int r = 0; r < 8; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        #3;
        do_reset();

        // 1: async reset mid-run clears pending write and sticky error
        wb_valid = 1'b1; wb_reg = 3'd1;
        cycle("t1.underflow");
        idle();
        issue(2'b10, 16'h0300);
        cycle("t1.iss_r3");
        idle(); rd1 = 3'd3; rd1_en = 1'b1;
        #1 chk("t1.pre_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        for (int r = 0; r < 8; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        #1;
        chk("t1.async_busy", {24'd0, busy}, 32'd0);
        chk("t1.async_stall", {31'd0, stall}, 32'd0);
        chk("t1.async_err", {31'd0, sb_err}, 32'd0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: RAW stall on R3 and release at writeback
        issue(2'b10, 16'h0300);
        cycle("t2.iss");
        idle(); rd1 = 3'd3; rd1_en = 1'b1;
        #1 chk("t2.raw_stall", {31'd0, stall}, 32'd1);
        cycle("t2.hold");
        wb_valid = 1'b1; wb_reg = 3'd3;
        #1 chk("t2.wb_stall", {31'd0, stall}, BYP ? 32'd0 : 32'd1);
        cycle("t2.wb");
        wb_valid = 1'b0;
        #1 chk("t2.released", {31'd0, stall}, 32'd0);
        cycle("t2.after");

        // 3: saturate R5, fourth issue stalls until a retire frees a slot
        idle();
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, 16'h00A0);
            cycle("t3.fill");
        end
        chk("t3.busy5", {31'd0, busy[5]}, 32'd1);
        #1 chk("t3.sat_stall", {31'd0, stall}, 32'd1);
        cycle("t3.sat_hold");
        wb_valid = 1'b1; wb_reg = 3'd5;
        cycle("t3.retire");
        wb_valid = 1'b0;
        #1 chk("t3.accept", {31'd0, stall}, 32'd0);
        cycle("t3.refill");
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_reg = 3'd5;
            cycle("t3.drain");
        end
        idle();
        chk("t3.empty", {24'd0, busy}, 32'd0);

        // 4: same-cycle issue and retire on R2 leaves count unchanged
        issue(2'b01, 16'h0008);
        cycle("t4.iss");
        wb_valid = 1'b1; wb_reg = 3'd2;
        cycle("t4.both");
        chk("t4.busy2", {31'd0, busy[2]}, 32'd1);
        idle(); wb_valid = 1'b1; wb_reg = 3'd2;
        cycle("t4.drain");
        idle();
        chk("t4.empty", {24'd0, busy}, 32'd0);

        // 5: JAL link register and read-enable qualification
        issue(2'b11, 16'hFFFF);
        cycle("t5.jal");
        chk("t5.busy7", {31'd0, busy[7]}, 32'd1);
        idle(); rd2 = 3'd7; rd2_en = 1'b0;
        #1 chk("t5.no_en", {31'd0, stall}, 32'd0);
        rd2_en = 1'b1;
        #1 chk("t5.en", {31'd0, stall}, 32'd1);
        cycle("t5.hold");
        idle(); wb_valid = 1'b1; wb_reg = 3'd7;
        cycle("t5.drain");

        // 6: flush squashes pending writes; a stray retire sets sticky error
        idle();
        issue(2'b00, 16'h0020);
        cycle("t6.iss1");
        issue(2'b00, 16'h0080);
        cycle("t6.iss4");
        idle(); flush = 1'b1; wb_valid = 1'b1; wb_reg = 3'd1;
        cycle("t6.flush");
        chk("t6.flushed", {24'd0, busy}, 32'd0);
        chk("t6.no_err", {31'd0, sb_err}, 32'd0);
        idle(); wb_valid = 1'b1; wb_reg = 3'd4;
        cycle("t6.stray");
        chk("t6.err", {31'd0, sb_err}, 32'd1);
        idle();
        cycle("t6.sticky1");
        cycle("t6.sticky2");
        chk("t6.err_held", {31'd0, sb_err}, 32'd1);

        // random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 0) do_reset();
            iss_valid  = ($urandom % 4) != 0;
            iss_wr_en  = ($urandom % 4) != 0;
            iss_wr_sel = 2'($urandom);
            iss_instr  = 16'($urandom);
            rd1 = 3'($urandom); rd2 = 3'($urandom);
            rd1_en = ($urandom % 3) == 0;
            rd2_en = ($urandom % 3) == 0;
            flush  = ($urandom % 40) == 0;
            cands.delete();
            for (int r = 0; r < 8; r++) if (cnt_m[r] > 0) cands.push_back(r);
            wb_valid = 1'b0;
            if (cands.size() > 0 && ($urandom % 2) == 1) begin
                wb_valid = 1'b1;
                wb_reg   = 3'(cands[$urandom_range(0, cands.size() - 1)]);
            end else if (($urandom % 60) == 0) begin
                wb_valid = 1'b1;
                wb_reg   = 3'($urandom);
            end
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
